// File: rtl/serial_acc_if.sv
// serial_acc_if: product input and result output handshake bundle for serial_acc
interface serial_acc_if #(
    parameter int width = 8,
    parameter int GUARD = 2
);
    localparam int W     = 2 * width;
    localparam int ACC_W = W + GUARD;
    logic signed [W-1:0]     d_in;
    logic                    d_in_vld;
    logic                    d_in_rdy;
    logic                    acc_clr;
    logic signed [ACC_W-1:0] d_out;
    logic signed [W-1:0]     d_out_sat;
    logic                    d_out_ovf;
    logic                    d_out_vld;
    logic                    d_out_rdy;
    modport master (
        output d_in, d_in_vld, acc_clr, d_out_rdy,
        input  d_in_rdy, d_out, d_out_sat, d_out_ovf, d_out_vld
    );
    modport slave (
        input  d_in, d_in_vld, acc_clr, d_out_rdy,
        output d_in_rdy, d_out, d_out_sat, d_out_ovf, d_out_vld
    );
endinterface

// File: rtl/serial_acc.sv
// serial_acc: sums groups of LEN signed products and presents full-precision and saturated results
module serial_acc #(
    parameter int width = 8,
    parameter int LEN   = 4,
    parameter int GUARD = 2
) (
    input logic        clk,
    input logic        asyn_reset,
    serial_acc_if.slave bus
);
    localparam int W     = 2 * width;
    localparam int ACC_W = W + GUARD;
    localparam int CW    = $clog2(LEN);
    typedef enum logic {ACC, HOLD} state_t;
    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, d_out_q, d_out_d, sum;
    logic signed [W-1:0]     sat_q, sat_d, sat;
    logic                    ovf_q, ovf_d, ovf;
    logic                    in_rdy, accept, transfer, last;
    logic [GUARD:0]          top;
    // state register plus datapath flops
    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            state_q <= ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
            d_out_q <= '0;
            sat_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            d_out_q <= d_out_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
        end
    end
    // handshake decode, running sum and clamp of the candidate result
    always_comb begin
        in_rdy   = state_q == ACC && !bus.acc_clr;
        accept   = bus.d_in_vld && in_rdy;
        transfer = state_q == HOLD && bus.d_out_rdy;
        last     = cnt_q == CW'(LEN - 1);
        sum      = (cnt_q == '0 ? '0 : acc_q) + {{GUARD{bus.d_in[W-1]}}, bus.d_in};
        top      = sum[ACC_W-1:W-1];
        ovf      = !(&top || !(|top));
        sat      = ovf ? {sum[ACC_W-1], {(W-1){~sum[ACC_W-1]}}} : sum[W-1:0];
    end
    // next state: last accept forms a result, transfer releases it
    always_comb begin
        state_d = state_q;
        if (state_q == ACC && accept && last)
            state_d = HOLD;
        else if (transfer)
            state_d = ACC;
    end
    // next datapath values; abort only acts while collecting
    always_comb begin
        cnt_d   = accept ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        acc_d   = accept ? sum : acc_q;
        d_out_d = accept && last ? sum : d_out_q;
        sat_d   = accept && last ? sat : sat_q;
        ovf_d   = accept && last ? ovf : ovf_q;
        if (state_q == ACC && bus.acc_clr) begin
            cnt_d = '0;
            acc_d = '0;
        end
    end
    // outputs
    always_comb begin
        bus.d_in_rdy  = in_rdy;
        bus.d_out_vld = state_q == HOLD;
        bus.d_out     = d_out_q;
        bus.d_out_sat = sat_q;
        bus.d_out_ovf = ovf_q;
    end
endmodule

// File: tb/tb_serial_acc.sv
// tb_serial_acc: scoreboard bench for serial_acc (width 8, LEN 4, GUARD 2)
module tb_serial_acc;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   m_acc = 0;
    int   m_cnt = 0;
    typedef struct {
        logic [17:0] d;
        logic [15:0] s;
        logic        o;
    } exp_t;
    exp_t sb[$];

    serial_acc_if #(.width(8), .GUARD(2)) bus();
    serial_acc #(.width(8), .LEN(4), .GUARD(2)) dut (.clk(clk), .asyn_reset(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int v);
        bit ok = 0;
        bus.d_in = 16'(v);
        bus.d_in_vld = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.d_in_rdy) begin
                ok = 1;
                break;
            end
        end
        step();
        bus.d_in_vld = 1'b0;
        if (!ok) chk("rdy_timeout", 0, 1);
        else begin
            m_acc = (m_cnt == 0) ? v : m_acc + v;
            m_cnt++;
            if (m_cnt == 4) begin
                exp_t e;
                e.d = m_acc[17:0];
                e.o = m_acc > 32767 || m_acc < -32768;
                e.s = m_acc > 32767 ? 16'h7fff : m_acc < -32768 ? 16'h8000 : m_acc[15:0];
                sb.push_back(e);
                m_cnt = 0;
            end
        end
    endtask

    // compare presented results against the scoreboard every cycle they are held
    always @(negedge clk) begin
        if (!rst && bus.d_out_vld) begin
            if (sb.size() == 0) chk("unexp_out", 1, 0);
            else begin
                chk("d_out", {14'b0, bus.d_out}, {14'b0, sb[0].d});
                chk("d_out_sat", {16'b0, bus.d_out_sat}, {16'b0, sb[0].s});
                chk("d_out_ovf", {31'b0, bus.d_out_ovf}, {31'b0, sb[0].o});
                chk("rdy_in_hold", {31'b0, bus.d_in_rdy}, 0);
                if (bus.d_out_rdy) void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.d_in = '0;
        bus.d_in_vld = 1'b0;
        bus.acc_clr = 1'b0;
        bus.d_out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_vld", {31'b0, bus.d_out_vld}, 0);
        chk("rst_dout", {14'b0, bus.d_out}, 0);
        chk("rst_sat", {16'b0, bus.d_out_sat}, 0);
        chk("rst_ovf", {31'b0, bus.d_out_ovf}, 0);
        chk("rst_rdy", {31'b0, bus.d_in_rdy}, 1);
        step();
        // streaming
        put(100); put(200); put(300); put(400);
        @(negedge clk);
        chk("vld_latency", {31'b0, bus.d_out_vld}, 1);
        chk("rdy_low", {31'b0, bus.d_in_rdy}, 0);
        step();
        @(negedge clk);
        chk("vld_clear", {31'b0, bus.d_out_vld}, 0);
        chk("rdy_back", {31'b0, bus.d_in_rdy}, 1);
        step();
        // backpressure: pending input must wait for the transfer
        bus.d_out_rdy = 1'b0;
        put(100); put(200); put(300); put(400);
        fork
            begin
                repeat (5) @(posedge clk);
                #1 bus.d_out_rdy = 1'b1;
            end
        join_none
        put(7); put(8); put(9); put(10);
        // saturation both ways
        put(32767); put(32767); put(32767); put(32767);
        put(-32768); put(-32768); put(-32768); put(-32768);
        // abort mid-group
        put(50); put(60);
        bus.acc_clr = 1'b1;
        bus.d_in = 16'd99;
        bus.d_in_vld = 1'b1;
        @(negedge clk);
        chk("clr_rdy", {31'b0, bus.d_in_rdy}, 0);
        step();
        bus.acc_clr = 1'b0;
        bus.d_in_vld = 1'b0;
        m_cnt = 0;
        put(1); put(2); put(3); put(4);
        // reset while holding a result
        step();
        bus.d_out_rdy = 1'b0;
        put(1); put(1); put(1); put(1);
        @(negedge clk);
        step();
        sb.delete();
        m_cnt = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_vld", {31'b0, bus.d_out_vld}, 0);
        chk("midrst_dout", {14'b0, bus.d_out}, 0);
        chk("midrst_rdy", {31'b0, bus.d_in_rdy}, 1);
        step();
        bus.d_out_rdy = 1'b1;
        put(-5); put(-5); put(3); put(2);
        repeat (3) step();
        chk("drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
